// File: rtl/mips_qissue_ctrl.sv
// Registered MIPS opcode decoder extended with a COP2 quantum-instruction queue,
// QPU valid/ready issue, outstanding-op tracking, QBARRIER fetch stall and timeout recovery.
module mips_qissue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUT    = 2,
    parameter int QREG_W     = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          instr_valid,
    input  logic [31:0]                   instr,
    output logic                          decode_ready,
    output logic                          ctrl_valid,
    output logic                          reg_dst,
    output logic                          branch,
    output logic                          jump,
    output logic                          mem_read,
    output logic                          mem_to_reg,
    output logic                          mem_write,
    output logic                          alu_src,
    output logic                          reg_write,
    output logic [1:0]                    alu_op,
    output logic                          illegal_op,
    output logic                          q_valid,
    input  logic                          q_ready,
    output logic [4:0]                    q_op,
    output logic [QREG_W-1:0]             q_target,
    output logic [QREG_W-1:0]             q_control,
    input  logic                          q_done,
    output logic [3:0]                    q_outstanding,
    output logic [$clog2(FIFO_DEPTH):0]   q_fifo_count,
    output logic                          stall,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 5 + 2 * QREG_W;
    localparam logic [5:0]    OPC_RTYPE    = 6'b000000;
    localparam logic [5:0]    OPC_ADDI     = 6'b001000;
    localparam logic [5:0]    OPC_J        = 6'b000010;
    localparam logic [5:0]    OPC_COP2     = 6'b010010;
    localparam logic [4:0]    SUB_QBARRIER = 5'b11111;
    localparam logic [CW-1:0] FIFO_FULL_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE_C    = CW'(1'b1);
    localparam logic [PW-1:0] PTR_ONE_C    = PW'(1'b1);
    localparam logic [3:0]    MAX_OUT_C    = 4'(MAX_OUT);
    localparam logic [15:0]   TO_LAST_C    = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BARRIER = 2'd1,
        ST_ERROR   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_base_s;
    state_t            state_nxt_s;
    logic [EW-1:0]     mem_r [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [3:0]        out_r;
    logic [15:0]       tcnt_r;
    logic              err_r;
    logic [EW-1:0]     head_s;
    logic [EW-1:0]     entry_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic              is_cop2_s;
    logic              is_barrier_s;
    logic              accept_s;
    logic              push_s;
    logic              issue_s;
    logic              done_s;
    logic              timeout_hit_s;
    logic              unused_s;

    assign unused_s      = ^instr;
    assign is_cop2_s     = (instr[31:26] == OPC_COP2);
    assign is_barrier_s  = is_cop2_s && (instr[25:21] == SUB_QBARRIER);
    assign fifo_empty_s  = (count_r == {CW{1'b0}});
    assign fifo_full_s   = (count_r == FIFO_FULL_C);
    assign entry_s       = {instr[25:21], instr[16 +: QREG_W], instr[11 +: QREG_W]};

    // Classic instructions are never held back by a full quantum queue.
    assign decode_ready  = (state_r == ST_RUN) && !(is_cop2_s && fifo_full_s);
    assign stall         = !decode_ready;
    assign accept_s      = instr_valid && decode_ready;
    assign push_s        = accept_s && is_cop2_s && !is_barrier_s;

    assign q_valid       = !fifo_empty_s && (out_r < MAX_OUT_C) && (state_r != ST_ERROR);
    assign issue_s       = q_valid && q_ready;
    assign done_s        = q_done && (out_r != 4'd0);
    assign timeout_hit_s = (out_r != 4'd0) && !q_done && !issue_s && (tcnt_r == TO_LAST_C);

    assign head_s        = fifo_empty_s ? {EW{1'b0}} : mem_r[rd_ptr_r];
    assign {q_op, q_target, q_control} = head_s;
    assign q_outstanding = out_r;
    assign q_fifo_count  = count_r;
    assign timeout_err   = err_r;

    // Next-state selection; a timeout overrides every other transition.
    always_comb begin
        state_base_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s && is_barrier_s) state_base_s = ST_BARRIER;
                else                          state_base_s = ST_RUN;
            end
            ST_BARRIER: begin
                if (fifo_empty_s && (out_r == 4'd0)) state_base_s = ST_RUN;
                else                                 state_base_s = ST_BARRIER;
            end
            ST_ERROR: begin
                if (err_clr) state_base_s = ST_RUN;
                else         state_base_s = ST_ERROR;
            end
            default: state_base_s = ST_RUN;
        endcase
        state_nxt_s = timeout_hit_s ? ST_ERROR : state_base_s;
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_RUN;
        else     state_r <= state_nxt_s;
    end

    // One-cycle-registered classic datapath controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_valid <= 1'b0;
            reg_dst    <= 1'b0;
            branch     <= 1'b0;
            jump       <= 1'b0;
            mem_read   <= 1'b0;
            mem_to_reg <= 1'b0;
            mem_write  <= 1'b0;
            alu_src    <= 1'b0;
            reg_write  <= 1'b0;
            alu_op     <= 2'b00;
            illegal_op <= 1'b0;
        end else begin
            ctrl_valid <= accept_s;
            reg_dst    <= 1'b0;
            branch     <= 1'b0;
            jump       <= 1'b0;
            mem_read   <= 1'b0;
            mem_to_reg <= 1'b0;
            mem_write  <= 1'b0;
            alu_src    <= 1'b0;
            reg_write  <= 1'b0;
            alu_op     <= 2'b00;
            illegal_op <= 1'b0;
            if (accept_s) begin
                case (instr[31:26])
                    OPC_RTYPE: begin
                        reg_dst   <= 1'b1;
                        reg_write <= 1'b1;
                        alu_op    <= 2'b10;
                    end
                    OPC_ADDI: begin
                        alu_src   <= 1'b1;
                        reg_write <= 1'b1;
                    end
                    OPC_J:    jump       <= 1'b1;
                    OPC_COP2: illegal_op <= 1'b0;
                    default:  illegal_op <= 1'b1;
                endcase
            end
        end
    end

    // Quantum instruction queue; entering ERROR flushes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {EW{1'b0}};
        end else if (timeout_hit_s) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE_C;
            end
            if (issue_s) rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            case ({push_s, issue_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Issued-but-not-completed QPU operation count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r <= 4'd0;
        end else if (timeout_hit_s) begin
            out_r <= 4'd0;
        end else begin
            case ({issue_s, done_s})
                2'b10:   out_r <= out_r + 4'd1;
                2'b01:   out_r <= out_r - 4'd1;
                default: out_r <= out_r;
            endcase
        end
    end

    // Progress watchdog and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_r <= 16'd0;
            err_r  <= 1'b0;
        end else begin
            if (q_done || issue_s || (out_r == 4'd0) || timeout_hit_s) tcnt_r <= 16'd0;
            else                                                      tcnt_r <= tcnt_r + 16'd1;
            if (timeout_hit_s)                         err_r <= 1'b1;
            else if ((state_r == ST_ERROR) && err_clr) err_r <= 1'b0;
            else                                       err_r <= err_r;
        end
    end

endmodule

// File: tb/tb_mips_qissue_ctrl.sv
// Self-checking bench: decode vector table, hand-written queue/barrier/timeout/reset
// sequences and a randomized run, all compared against a queue-based reference model.
module tb_mips_qissue_ctrl;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_OUT    = 2;
    localparam int QREG_W     = 4;
    localparam int TIMEOUT    = 8;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int M_RUN = 0, M_BAR = 1, M_ERR = 2;

    logic clk, rst, instr_valid, decode_ready, ctrl_valid;
    logic reg_dst, branch, jump, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [31:0] instr;
    logic [1:0] alu_op;
    logic illegal_op, q_valid, q_ready, q_done, stall, timeout_err, err_clr;
    logic [4:0] q_op;
    logic [QREG_W-1:0] q_target, q_control;
    logic [3:0] q_outstanding;
    logic [CW-1:0] q_fifo_count;

    mips_qissue_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_OUT(MAX_OUT), .QREG_W(QREG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .decode_ready(decode_ready),
        .ctrl_valid(ctrl_valid), .reg_dst(reg_dst), .branch(branch), .jump(jump), .mem_read(mem_read),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
        .alu_op(alu_op), .illegal_op(illegal_op), .q_valid(q_valid), .q_ready(q_ready), .q_op(q_op),
        .q_target(q_target), .q_control(q_control), .q_done(q_done), .q_outstanding(q_outstanding),
        .q_fifo_count(q_fifo_count), .stall(stall), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [4:0]        op;
        logic [QREG_W-1:0] tgt;
        logic [QREG_W-1:0] ctl;
    } q_entry_t;

    typedef struct {
        logic [31:0] instr;
        logic [10:0] ctrl;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference model: pending queue, outstanding count, mode, sticky error, stall-cycle count.
    q_entry_t    mq[$];
    int          m_out, m_idle, m_state;
    bit          m_err, m_cvalid;
    logic [10:0] m_ctrl;

    function automatic logic [10:0] mk(bit rd, bit br, bit j, bit mr, bit mtr, bit mw, bit as, bit rw,
                                       logic [1:0] aop, bit ill);
        return {rd, br, j, mr, mtr, mw, as, rw, aop, ill};
    endfunction

    function automatic logic [10:0] dut_ctrl();
        return {reg_dst, branch, jump, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op, illegal_op};
    endfunction

    function automatic logic [10:0] expect_ctrl(logic [5:0] opc);
        if (opc == 6'b000000) return mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0);
        if (opc == 6'b001000) return mk(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0);
        if (opc == 6'b000010) return mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
        if (opc == 6'b010010) return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    endfunction

    function automatic logic [31:0] cop2(logic [4:0] op, logic [3:0] t, logic [3:0] c);
        return {6'b010010, op, 1'b0, t, 1'b0, c, 11'h000};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[31:26] = 6'b000000;
            1: w[31:26] = 6'b001000;
            2: w[31:26] = 6'b000010;
            3, 4, 5: begin
                w[31:26] = 6'b010010;
                w[25:21] = ($urandom_range(0, 5) == 0) ? 5'b11111 : 5'($urandom_range(0, 30));
            end
            default: w = w;
        endcase
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out = 0; m_idle = 0; m_state = M_RUN; m_err = 0; m_cvalid = 0; m_ctrl = '0;
    endtask

    task automatic check_model();
        bit cop2_i, rdy, qv;
        q_entry_t head;
        cop2_i = (instr[31:26] == 6'b010010);
        rdy    = (m_state == M_RUN) && !(cop2_i && mq.size() == FIFO_DEPTH);
        qv     = (mq.size() > 0) && (m_out < MAX_OUT) && (m_state != M_ERR);
        head   = '0;
        if (mq.size() > 0) head = mq[0];
        chk("decode_ready", 32'(decode_ready), 32'(rdy));
        chk("stall", 32'(stall), 32'(!rdy));
        chk("q_valid", 32'(q_valid), 32'(qv));
        chk("q_op", 32'(q_op), 32'(head.op));
        chk("q_target", 32'(q_target), 32'(head.tgt));
        chk("q_control", 32'(q_control), 32'(head.ctl));
        chk("q_fifo_count", 32'(q_fifo_count), 32'(mq.size()));
        chk("q_outstanding", 32'(q_outstanding), 32'(m_out));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        chk("ctrl_valid", 32'(ctrl_valid), 32'(m_cvalid));
        chk("ctrl_vec", 32'(dut_ctrl()), 32'(m_ctrl));
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit cop2_i, bar, rdy, acc, qv, iss, dn, fire;
        int old_size, old_out;
        q_entry_t e;
        cop2_i   = (instr[31:26] == 6'b010010);
        bar      = cop2_i && (instr[25:21] == 5'b11111);
        rdy      = (m_state == M_RUN) && !(cop2_i && mq.size() == FIFO_DEPTH);
        qv       = (mq.size() > 0) && (m_out < MAX_OUT) && (m_state != M_ERR);
        acc      = instr_valid && rdy;
        iss      = qv && q_ready;
        dn       = q_done && (m_out > 0);
        fire     = (m_out > 0) && !q_done && !iss && (m_idle + 1 >= TIMEOUT);
        old_size = mq.size();
        old_out  = m_out;
        m_cvalid = acc;
        m_ctrl   = acc ? expect_ctrl(instr[31:26]) : 11'd0;
        if (fire) begin
            mq.delete();
            m_out = 0; m_idle = 0; m_err = 1; m_state = M_ERR;
        end else begin
            if (iss) void'(mq.pop_front());
            if (acc && cop2_i && !bar) begin
                e.op = instr[25:21]; e.tgt = instr[16 +: QREG_W]; e.ctl = instr[11 +: QREG_W];
                mq.push_back(e);
            end
            m_out = m_out + (iss ? 1 : 0) - (dn ? 1 : 0);
            if (q_done || iss || old_out == 0) m_idle = 0;
            else                               m_idle++;
            if (m_state == M_RUN && acc && bar) m_state = M_BAR;
            else if (m_state == M_BAR && old_size == 0 && old_out == 0) m_state = M_RUN;
            else if (m_state == M_ERR && err_clr) begin m_state = M_RUN; m_err = 0; end
        end
    endtask

    task automatic cycle();
        #1;
        check_model();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; instr_valid = 1'b0; instr = 32'd0; q_ready = 1'b0; q_done = 1'b0; err_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        #1 check_model();
        rst = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h012A4020, mk(1, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0)};
        vecs[1] = '{32'h20080005, mk(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0)};
        vecs[2] = '{32'hFC000000, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1)};
        vecs[3] = '{32'h08000010, mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0)};
        vecs[4] = '{32'h8C220004, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1)};
        vecs[5] = '{32'h10220003, mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1)};

        apply_reset();

        // Classic decode table.
        foreach (vecs[i]) begin
            instr_valid = 1'b1; instr = vecs[i].instr;
            cycle();
            instr_valid = 1'b0;
            #1;
            chk("tbl_valid", 32'(ctrl_valid), 32'd1);
            chk("tbl_ctrl", 32'(dut_ctrl()), 32'(vecs[i].ctrl));
        end
        cycle();

        // Fill the queue with the QPU stalled; classic instructions still flow.
        q_ready = 1'b0; q_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            instr_valid = 1'b1; instr = cop2(5'(k + 1), 4'(k + 2), 4'(k + 7));
            cycle();
        end
        instr = cop2(5'd5, 4'd6, 4'd11);
        #1;
        chk("full_count", 32'(q_fifo_count), 32'd4);
        chk("full_ready", 32'(decode_ready), 32'd0);
        chk("full_stall", 32'(stall), 32'd1);
        cycle();
        instr = 32'h20080005;
        #1 chk("addi_when_full", 32'(decode_ready), 32'd1);
        cycle();
        instr_valid = 1'b0;
        #1 chk("addi_ctrl", 32'(dut_ctrl()), 32'(mk(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0)));
        q_ready = 1'b1; q_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("order_valid", 32'(q_valid), 32'd1);
            chk("order_op", 32'(q_op), 32'(k + 1));
            chk("order_tgt", 32'(q_target), 32'(k + 2));
            cycle();
        end
        q_ready = 1'b0;
        cycle();
        q_done = 1'b0;
        cycle();

        // Outstanding limit and simultaneous issue/done.
        q_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr_valid = 1'b1; instr = cop2(5'(k + 9), 4'(k), 4'(15 - k));
            cycle();
        end
        instr_valid = 1'b0;
        cycle();
        #1;
        chk("limit_out", 32'(q_outstanding), 32'd2);
        chk("limit_valid", 32'(q_valid), 32'd0);
        chk("limit_fifo", 32'(q_fifo_count), 32'd1);
        q_done = 1'b1;
        cycle();
        q_done = 1'b0;
        #1 chk("refill_valid", 32'(q_valid), 32'd1);
        cycle();
        #1 chk("refill_out", 32'(q_outstanding), 32'd2);
        instr_valid = 1'b1; instr = cop2(5'd20, 4'd3, 4'd4); q_done = 1'b1;
        cycle();
        instr_valid = 1'b0;
        #1;
        chk("same_pre_valid", 32'(q_valid), 32'd1);
        chk("same_pre_out", 32'(q_outstanding), 32'd1);
        cycle();
        #1 chk("same_cycle_out", 32'(q_outstanding), 32'd1);
        cycle();
        q_done = 1'b0; q_ready = 1'b0;
        cycle();

        // QBARRIER holds fetch until the QPU drains.
        for (int k = 0; k < 2; k++) begin
            instr_valid = 1'b1; instr = cop2(5'(k + 3), 4'(k + 8), 4'(k + 1));
            cycle();
        end
        instr = cop2(5'b11111, 4'd0, 4'd0);
        cycle();
        instr = 32'h20080005;
        #1;
        chk("barrier_no_push", 32'(q_fifo_count), 32'd2);
        chk("barrier_ready", 32'(decode_ready), 32'd0);
        q_ready = 1'b1;
        cycle();
        cycle();
        q_ready = 1'b0; q_done = 1'b1;
        cycle();
        cycle();
        q_done = 1'b0;
        #1;
        chk("barrier_drained", 32'(q_outstanding), 32'd0);
        chk("barrier_hold", 32'(decode_ready), 32'd0);
        cycle();
        #1 chk("barrier_release", 32'(decode_ready), 32'd1);
        cycle();
        instr_valid = 1'b0;
        cycle();

        // Timeout with one op outstanding and one queued, then recovery.
        q_ready = 1'b1; instr_valid = 1'b1; instr = cop2(5'd7, 4'd5, 4'd9);
        cycle();
        instr = cop2(5'd8, 4'd6, 4'd10);
        cycle();
        q_ready = 1'b0; instr_valid = 1'b0; instr = 32'd0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            #1 chk("timeout_step", 32'(timeout_err), 32'(k == 8));
        end
        chk("err_fifo", 32'(q_fifo_count), 32'd0);
        chk("err_out", 32'(q_outstanding), 32'd0);
        chk("err_qvalid", 32'(q_valid), 32'd0);
        chk("err_ready", 32'(decode_ready), 32'd0);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        #1;
        chk("clr_err", 32'(timeout_err), 32'd0);
        chk("clr_ready", 32'(decode_ready), 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        cycle();

        // Asynchronous reset in the middle of a stalled handshake.
        q_ready = 1'b1; instr_valid = 1'b1; instr = cop2(5'd1, 4'd1, 4'd1);
        cycle();
        instr = cop2(5'd2, 4'd2, 4'd2);
        cycle();
        q_ready = 1'b0; instr = cop2(5'd3, 4'd3, 4'd3);
        cycle();
        instr = cop2(5'd4, 4'd4, 4'd4);
        cycle();
        instr_valid = 1'b0;
        #1;
        chk("pre_rst_valid", 32'(q_valid), 32'd1);
        chk("pre_rst_fifo", 32'(q_fifo_count), 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("rst_qvalid", 32'(q_valid), 32'd0);
        chk("rst_fifo", 32'(q_fifo_count), 32'd0);
        chk("rst_out", 32'(q_outstanding), 32'd0);
        chk("rst_qop", 32'({q_op, q_target, q_control}), 32'd0);
        chk("rst_ctrl", 32'({ctrl_valid, dut_ctrl()}), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0; q_ready = 1'b1; instr_valid = 1'b1; instr = cop2(5'd17, 4'd12, 4'd13);
        cycle();
        instr_valid = 1'b0;
        #1;
        chk("post_rst_valid", 32'(q_valid), 32'd1);
        chk("post_rst_op", 32'(q_op), 32'd17);
        cycle();
        q_done = 1'b1;
        cycle();
        q_done = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            int done_pct;
            done_pct    = ((i / 100) % 2 == 1) ? 8 : 45;
            instr_valid = ($urandom_range(0, 1) == 1);
            instr       = rand_instr();
            q_ready     = ($urandom_range(0, 99) < 60);
            q_done      = ($urandom_range(0, 99) < done_pct);
            err_clr     = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_qissue_ctrl.md
Name: mips_qissue_ctrl

Overview:
- Registered successor of the MIPS opcode decoder.
- Classic opcodes produce one-cycle-registered datapath controls.
- COP2 quantum instructions (opcode 6'b010010) are enqueued in a parametrised FIFO and issued to the QPU over a valid/ready handshake.
- Tracks outstanding QPU operations, handles a QBARRIER sub-op that stalls fetch until the QPU drains, and raises a sticky timeout error with flush/recovery.

Parameters:
- FIFO_DEPTH, 4, quantum instruction queue entries; power of two, >=2.
- MAX_OUT, 2, maximum QPU ops issued but not yet completed; 1..15.
- QREG_W, 4, qubit index width; 1..5.
- TIMEOUT, 1023, cycles without q_done while outstanding>0 before error; >=1, fits 16 bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- instr_valid  in  1  instruction offered
- instr  in  32  instruction word; opcode = instr[31:26]
- decode_ready  out  1  instruction accepted when instr_valid && decode_ready
- ctrl_valid  out  1  registered controls below valid this cycle
- reg_dst, branch, jump, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  classic controls
- alu_op  out  2  ALU op class
- illegal_op  out  1  pulse with ctrl_valid for an unknown opcode
- q_valid  out  1  QPU command valid
- q_ready  in  1  QPU accepts command
- q_op  out  5  quantum sub-op = instr[25:21]
- q_target  out  QREG_W  instr[16+QREG_W-1:16]
- q_control  out  QREG_W  instr[11+QREG_W-1:11]
- q_done  in  1  one-cycle pulse per completed QPU op
- q_outstanding  out  4  issued-but-not-done count
- q_fifo_count  out  clog2(FIFO_DEPTH)+1  queue occupancy
- stall  out  1  = !decode_ready
- timeout_err  out  1  sticky error flag
- err_clr  in  1  clears error and returns to RUN

Behaviour:
- Reset: state=RUN, FIFO empty, counters 0, timeout_err=0, every control output, q_valid, q_op/q_target/q_control = 0. Asynchronous assertion at any point, including mid-handshake, discards queued and outstanding ops.
- Accept = instr_valid && decode_ready.
- decode_ready = (state==RUN) && !(quantum opcode && FIFO full). Classic instructions are never blocked by a full FIFO.
- Classic decode, registered, latency 1: the cycle after accept, ctrl_valid=1 with:
  - 000000: reg_dst=1, reg_write=1, alu_op=10
  - 001000: alu_src=1, reg_write=1, alu_op=00
  - 000010: jump=1
  - Any other non-COP2 opcode: all controls 0 and illegal_op=1.
  - Otherwise ctrl_valid=0 and all controls are 0.
- COP2 accept: ctrl_valid=1 next cycle with all controls 0, so no classic writeback.
  - sub-op != 5'b11111: push {q_op, target, control} into the FIFO.
  - sub-op == 5'b11111 (QBARRIER): nothing pushed; state -> BARRIER.
- Issue:
  - q_valid = FIFO non-empty && q_outstanding < MAX_OUT && state != ERROR.
  - q_op/q_target/q_control show the FIFO head and hold stable while q_valid && !q_ready.
  - On q_valid && q_ready: pop, q_outstanding+1.
- Completion: q_done decrements q_outstanding.
  - Issue and done in the same cycle: count unchanged.
  - q_done while q_outstanding==0: ignored, no underflow.
- FIFO: push and pop in the same cycle are both legal when non-empty; a push is refused at full; pointers wrap modulo FIFO_DEPTH.
- States:
  - RUN: normal operation.
  - BARRIER: decode_ready=0; issue continues. Go to RUN in the cycle after FIFO empty && q_outstanding==0.
  - ERROR: decode_ready=0, q_valid=0.
- Timeout:
  - Counter resets to 0 on q_done, on an issue handshake, or while q_outstanding==0; otherwise it increments.
  - Reaching TIMEOUT sets timeout_err=1 and state -> ERROR from any state.
  - On entering ERROR: FIFO flushed, q_outstanding=0.
- err_clr in ERROR: next cycle timeout_err=0, state=RUN. err_clr has no effect outside ERROR.

Test Plan:
1. Reset, then instr 0x012A4020 (R-type) -> next cycle ctrl_valid=1, reg_dst=1, reg_write=1, alu_op=10, illegal_op=0; instr 0x20080005 (ADDI) -> alu_src=1, reg_write=1, alu_op=00; opcode 6'b111111 -> illegal_op=1, all controls 0.
2. q_ready=0, push 5 COP2 ops with default depth 4 -> q_fifo_count=4, decode_ready=0 on the 5th, stall=1. An ADDI offered meanwhile is still accepted. Raise q_ready -> ops issue in push order with matching q_op/q_target.
3. q_ready=1, q_done withheld -> exactly MAX_OUT=2 issued, q_valid then drops. q_done pulse -> one more issues, q_outstanding stays 2. Issue and q_done in the same cycle -> count unchanged.
4. Two ops queued, then QBARRIER (instr[25:21]=11111) -> decode_ready=0 until both q_done seen; ready=1 the cycle after the count reaches 0; no FIFO entry for the barrier.
5. TIMEOUT=8, one op outstanding, no q_done -> timeout_err=1 after 8 cycles, FIFO and outstanding count 0, q_valid=0. Pulse err_clr -> timeout_err=0, decode_ready=1 next cycle.
6. Assert rst mid q_valid with q_ready=0 and 3 queued -> all outputs 0 immediately, q_fifo_count=0; normal issue resumes after deassertion.
